// File: rtl/sysa_pkg.sv
// Shared defaults and state encoding for the systolic-array sequencer.
package sysa_pkg;

  localparam int unsigned NDef  = 4;
  localparam int unsigned DwDef = 8;
  localparam int unsigned AwDef = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StFeed  = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/sysa_dly.sv
// Enable-gated delay line of configurable width and depth; depth 0 is a plain wire.
module sysa_dly #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  if (Depth == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};
    assign q = d;
  end else begin : g_pipe
    logic [Width-1:0] pipe_q [Depth];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned k = 0; k < Depth; k++) pipe_q[k] <= '0;
      end else if (en) begin
        pipe_q[0] <= d;
        for (int unsigned k = 1; k < Depth; k++) pipe_q[k] <= pipe_q[k-1];
      end
    end

    assign q = pipe_q[Depth-1];
  end

endmodule

// File: rtl/sysa_ctrl.sv
// Sequencer for a weight-stationary NxN systolic array: weight load, activation skew,
// result de-skew and stream handshakes.
module sysa_ctrl
  import sysa_pkg::*;
#(
  parameter int unsigned N  = NDef,
  parameter int unsigned DW = DwDef,
  parameter int unsigned AW = AwDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        num_rows,
  output logic              busy,
  output logic              done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [N*DW-1:0]   w_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [N*DW-1:0]   a_data,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [N*AW-1:0]   r_data,
  output logic              arr_clr,
  output logic              arr_en,
  output logic [N*N*DW-1:0] arr_w,
  output logic [N*DW-1:0]   arr_left,
  input  logic [N*AW-1:0]   arr_down
);

  localparam int unsigned DcW = $clog2(2 * N) + 1;

  state_e              state_q, state_d;
  logic [7:0]          m_q, vcnt_q, row_q;
  logic [DcW-1:0]      dcnt_q;
  logic [2*N-1:0]      tok_q;
  logic                r_valid_q, arr_clr_q;
  logic [N*AW-1:0]     r_data_q;
  logic [N*N*DW-1:0]   arr_w_q;

  logic                stall, adv, a_fire, w_fire, job_start;
  logic [N*DW-1:0]     skew_in;
  logic [N*AW-1:0]     deskew_out;

  // A result sitting unaccepted freezes the whole pipeline, PEs included.
  assign stall     = r_valid_q && !r_ready;
  assign adv       = !stall && (state_q == StDrain || (state_q == StFeed && a_valid));
  assign a_fire    = adv && (state_q == StFeed);
  assign w_fire    = (state_q == StLoad) && w_valid;
  assign job_start = (state_q == StIdle) && start;
  assign skew_in   = (state_q == StFeed) ? a_data : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  if (w_fire && row_q == 8'(N - 1)) state_d = (m_q == 8'd0) ? StDone : StFeed;
      StFeed:  if (a_fire && (vcnt_q + 8'd1) == m_q) state_d = StDrain;
      StDrain: if (adv && dcnt_q == DcW'(2 * N - 1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      m_q       <= '0;
      vcnt_q    <= '0;
      row_q     <= '0;
      dcnt_q    <= '0;
      tok_q     <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      arr_w_q   <= '0;
      arr_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arr_clr_q <= job_start;
      if (job_start) begin
        m_q    <= num_rows;
        row_q  <= '0;
        vcnt_q <= '0;
        dcnt_q <= '0;
      end
      if (w_fire) begin
        for (int unsigned r = 0; r < N; r++) begin
          if (row_q == 8'(r)) arr_w_q[r*N*DW +: N*DW] <= w_data;
        end
        row_q <= row_q + 8'd1;
      end
      if (a_fire) vcnt_q <= vcnt_q + 8'd1;
      if (adv && state_q == StDrain) dcnt_q <= dcnt_q + 1'b1;
      if (adv) begin
        tok_q     <= {tok_q[2*N-2:0], a_fire};
        r_valid_q <= tok_q[2*N-1];
        r_data_q  <= deskew_out;
      end else if (r_ready) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_skew
    sysa_dly #(
      .Width(DW),
      .Depth(i + 1)
    ) u_skew (
      .clk(clk),
      .rst(rst),
      .en (adv),
      .d  (skew_in[i*DW +: DW]),
      .q  (arr_left[i*DW +: DW])
    );
  end

  for (genvar j = 0; j < N; j++) begin : g_deskew
    sysa_dly #(
      .Width(AW),
      .Depth(N - 1 - j)
    ) u_deskew (
      .clk(clk),
      .rst(rst),
      .en (adv),
      .d  (arr_down[j*AW +: AW]),
      .q  (deskew_out[j*AW +: AW])
    );
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign w_ready = (state_q == StLoad);
  assign a_ready = (state_q == StFeed) && !stall;
  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;
  assign arr_clr = arr_clr_q;
  assign arr_en  = adv;
  assign arr_w   = arr_w_q;

endmodule

// File: tb/tb_sysa_ctrl.sv
// Scoreboard bench for sysa_ctrl with a behavioural PE grid and a matrix-product reference.
module tb_sysa_ctrl;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 16;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [7:0]        num_rows;
  logic              busy, done;
  logic              w_valid, w_ready;
  logic [N*DW-1:0]   w_data;
  logic              a_valid, a_ready;
  logic [N*DW-1:0]   a_data;
  logic              r_valid, r_ready;
  logic [N*AW-1:0]   r_data;
  logic              arr_clr, arr_en;
  logic [N*N*DW-1:0] arr_w;
  logic [N*DW-1:0]   arr_left;
  logic [N*AW-1:0]   arr_down;

  int n_checks = 0;
  int n_errors = 0;
  int wmat [N][N];
  logic [N*AW-1:0] exp_q[$];
  logic [N*DW-1:0] vecs[$];
  int cyc = 0, done_cnt = 0, first_rv = -1, acc_edge = 0, last_pop = -10, consec = 0;
  int hold = 0;
  bit rr_rand = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sysa_ctrl #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .arr_clr(arr_clr), .arr_en(arr_en), .arr_w(arr_w), .arr_left(arr_left),
    .arr_down(arr_down)
  );

  // PE grid: activations move right, partial sums move down, one register each per PE.
  logic [DW-1:0] pe_a [N][N];
  logic [AW-1:0] pe_p [N][N];

  function automatic logic [DW-1:0] pe_ain(int i, int j);
    if (j == 0) return arr_left[i*DW +: DW];
    return pe_a[i][j-1];
  endfunction

  function automatic logic [AW-1:0] pe_pin(int i, int j);
    if (i == 0) return '0;
    return pe_p[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (rst || arr_clr) begin
          pe_a[i][j] <= '0;
          pe_p[i][j] <= '0;
        end else if (arr_en) begin
          pe_a[i][j] <= pe_ain(i, j);
          pe_p[i][j] <= pe_pin(i, j) + AW'(pe_ain(i, j)) * AW'(arr_w[(i*N+j)*DW +: DW]);
        end
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_down
    assign arr_down[j*AW +: AW] = pe_p[N-1][j];
  end

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout, required handshake within budget", name);
  endtask

  function automatic logic [N*AW-1:0] ref_result(logic [N*DW-1:0] v);
    logic [N*AW-1:0] r;
    int s;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int i = 0; i < N; i++) s += int'(v[i*DW +: DW]) * wmat[i][j];
      r[j*AW +: AW] = AW'(s % 65536);
    end
    return r;
  endfunction

  function automatic logic [N*DW-1:0] pack4(int a0, int a1, int a2, int a3);
    return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  function automatic logic [N*DW-1:0] rand_vec();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom_range(0, 255));
    return v;
  endfunction

  function automatic logic [N*N*DW-1:0] exp_w();
    logic [N*N*DW-1:0] e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) e[(i*N+j)*DW +: DW] = DW'(wmat[i][j]);
    return e;
  endfunction

  // Consumer: ready unless a hold is pending or random backpressure is enabled.
  initial begin
    r_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold > 0) begin
        r_ready = 1'b0;
        hold--;
      end else begin
        r_ready = rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every result transfer.
  initial begin
    logic [N*AW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) done_cnt++;
        if (r_valid && first_rv < 0) first_rv = cyc;
        if (r_valid && r_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL spurious_r_valid: got r_data %0h, required no result", r_data);
          end else begin
            e = exp_q.pop_front();
            check("result", r_data, e);
            if (cyc == last_pop + 1) consec++;
            last_pop = cyc;
          end
        end
      end
    end
  end

  task automatic check_idle(string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_w_ready"}, w_ready, 0);
    check({tag, "_a_ready"}, a_ready, 0);
    check({tag, "_r_valid"}, r_valid, 0);
    check({tag, "_arr_en"}, arr_en, 0);
    check({tag, "_arr_clr"}, arr_clr, 0);
    check({tag, "_arr_w"}, arr_w, 0);
    check({tag, "_arr_left"}, arr_left, 0);
    check({tag, "_r_data"}, r_data, 0);
  endtask

  task automatic load_w();
    int t;
    for (int i = 0; i < N; i++) begin
      w_valid = 1'b1;
      for (int j = 0; j < N; j++) w_data[j*DW +: DW] = DW'(wmat[i][j]);
      t = 0;
      @(negedge clk);
      while (!w_ready && t < 100) begin
        t++;
        @(negedge clk);
      end
      if (!w_ready) fail("w_ready_timeout");
      @(posedge clk);
      #1;
      if (i == 0) check("arr_clr_drop", arr_clr, 0);
    end
    w_valid = 1'b0;
    w_data  = '0;
  endtask

  task automatic send_a(logic [N*DW-1:0] v);
    int t = 0;
    a_valid = 1'b1;
    a_data  = v;
    @(negedge clk);
    while (!a_ready && t < 2000) begin
      t++;
      @(negedge clk);
    end
    if (a_ready) begin
      exp_q.push_back(ref_result(v));
      acc_edge = cyc + 1;
    end else begin
      fail("a_ready_timeout");
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_data  = '0;
  endtask

  task automatic feed_all(int gap_mode);
    foreach (vecs[k]) begin
      if (k > 0 && gap_mode == 1) begin
        @(posedge clk);
        #1;
      end
      if (gap_mode == 2 && $urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      send_a(vecs[k]);
    end
  endtask

  task automatic stall_probe();
    int t = 0;
    int stalls = 0;
    logic [N*AW-1:0] held = '0;
    @(negedge clk);
    while (!r_valid && t < 2000) begin
      t++;
      @(negedge clk);
    end
    if (!r_valid) fail("stall_r_valid_timeout");
    hold = 5;
    repeat (8) begin
      @(negedge clk);
      if (r_valid && !r_ready) begin
        if (stalls == 0) held = r_data;
        else check("stall_r_data_held", r_data, held);
        check("stall_arr_en", arr_en, 0);
        check("stall_a_ready", a_ready, 0);
        stalls++;
      end
    end
    check("stall_cycles", stalls, 5);
  endtask

  task automatic run_job(int gap_mode, bit start_busy, bit do_stall);
    int t;
    done_cnt = 0;
    first_rv = -1;
    consec   = 0;
    last_pop = -10;
    check("idle_before_start", busy, 0);
    start    = 1'b1;
    num_rows = 8'(vecs.size());
    @(posedge clk);
    #1;
    check("arr_clr_pulse", arr_clr, 1);
    start    = start_busy;
    num_rows = 8'd7;
    load_w();
    start = 1'b0;
    check("arr_w_loaded", arr_w, exp_w());
    if (vecs.size() == 0) check("m0_done_after_load", done, 1);
    fork
      feed_all(gap_mode);
      if (do_stall) stall_probe();
    join
    t = 0;
    @(negedge clk);
    while (!done && t < 3000) begin
      t++;
      @(negedge clk);
    end
    check("done_seen", done, 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      t++;
      @(negedge clk);
    end
    check("results_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("still_idle", busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_rows = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    // Identity weights, single vector, latency measured in unstalled cycles.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wmat[i][j] = (i == j) ? 1 : 0;
    vecs = '{pack4(1, 2, 3, 4)};
    run_job(0, 1'b0, 1'b0);
    check("latency", first_rv - acc_edge, 2 * N);

    // Full matrix, back-to-back, with start held high while busy.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wmat[i][j] = i + j + 1;
    vecs = '{pack4(1, 0, 0, 0), pack4(0, 1, 0, 0), pack4(1, 1, 1, 1)};
    run_job(0, 1'b1, 1'b0);
    check("back_to_back_results", consec, 2);

    // Modulo wrap.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wmat[i][j] = 255;
    vecs = '{pack4(255, 255, 255, 255), pack4(255, 255, 255, 255)};
    run_job(0, 1'b0, 1'b0);

    // Backpressure mid-stream.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wmat[i][j] = $urandom_range(0, 255);
    vecs.delete();
    for (int k = 0; k < 10; k++) vecs.push_back(rand_vec());
    run_job(0, 1'b0, 1'b1);

    // Single-cycle bubbles between vectors.
    vecs = '{pack4(3, 1, 4, 1), pack4(5, 9, 2, 6), pack4(200, 17, 0, 99)};
    run_job(1, 1'b0, 1'b0);

    // M = 0.
    vecs.delete();
    run_job(0, 1'b0, 1'b0);

    // Reset during FEED, then a fresh job.
    start    = 1'b1;
    num_rows = 8'd6;
    done_cnt = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    load_w();
    for (int k = 0; k < 3; k++) send_a(rand_vec());
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle("rst_mid_job");
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_rst", done_cnt, 0);
    vecs = '{pack4(7, 8, 9, 10), pack4(0, 0, 0, 1)};
    run_job(0, 1'b0, 1'b0);

    // Long random job at M = 255 with random gaps and random backpressure.
    rr_rand = 1'b1;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wmat[i][j] = $urandom_range(0, 255);
    vecs.delete();
    for (int k = 0; k < 255; k++) vecs.push_back(rand_vec());
    run_job(2, 1'b0, 1'b0);
    rr_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sysa_ctrl.md
# sysa_ctrl

Sequencer for the weight-stationary N×N systolic array built from 8-bit×8-bit/16-bit-accumulate processing elements.
- Loads and holds the array's weights.
- Skews the incoming activation vectors onto the array's left edge and drives the array's broadcast enable.
- De-skews the column sums leaving the bottom edge into aligned result vectors.
- Handles ready/valid handshakes with the producer and consumer.

It sits between the SoC-side streams and the PE grid.

## Interface
Parameters:
- N, 4: array dimension (rows = columns = N), N ≥ 2.
- DW, 8: activation/weight width.
- AW, 16: partial-sum/result width.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begin a job; sampled only in IDLE.
- num_rows, input, 8: number of activation vectors M, sampled with start.
- busy, output, 1: high in any state except IDLE.
- done, output, 1: one-cycle pulse at job end.
- w_valid / w_ready, input / output, 1: weight-row stream handshake.
- w_data, input, N*DW: weight row, lane j = W[i][j].
- a_valid / a_ready, input / output, 1: activation stream handshake.
- a_data, input, N*DW: activation vector, lane i = a_i.
- r_valid / r_ready, output / input, 1: result stream handshake.
- r_data, output, N*AW: result vector, lane j = Σ_i a_i·W[i][j] mod 2^AW.
- arr_clr, output, 1: clear pulse to the PE resets.
- arr_en, output, 1: broadcast PE enable.
- arr_w, output, N*N*DW: held weights, index i*N+j.
- arr_left, output, N*DW: skewed left-edge inputs.
- arr_down, input, N*AW: bottom-row down outputs.

## Operation
- **States:** IDLE → LOAD → FEED → DRAIN → DONE → IDLE.
- **IDLE:**
  - On start: latch num_rows, clear the weight-row counter, and pulse arr_clr for 1 cycle.
  - Go to LOAD.
  - A start seen outside IDLE is ignored.
- **LOAD:**
  - w_ready = 1.
  - Each w_valid&&w_ready beat writes row counter i into arr_w row i.
  - After beat N-1: go to FEED, or to DONE if M = 0.
- **adv (global step):** adv = !(r_valid && !r_ready) && (state==DRAIN || (state==FEED && a_valid)).
  - arr_en = adv.
  - Every skew, de-skew, token and output register updates only on adv.
- **FEED:**
  - a_ready = !(r_valid && !r_ready).
  - Each accepted vector enters the skew network.
  - After the M-th acceptance, go to DRAIN.
- **DRAIN:**
  - Zeros are injected into the skew network.
  - Exit to DONE after exactly 2N adv steps.
- **DONE:** done = 1 for one cycle, then IDLE.
- **Skew:**
  - arr_left lane i is a_data lane i delayed through i+1 adv-gated registers.
  - Bubbles and drain inject 0.
- **De-skew:** arr_down lane j passes through N-1-j adv-gated registers.
- **Output register:**
  - r_data is captured from the de-skew stage on adv.
  - r_valid follows a valid-token shift register of depth 2N, fed 1 per accepted vector and 0 otherwise.
  - r_valid clears on r_ready when no new token arrives.
- **Arithmetic:** 16-bit modulo wrap. No saturation, no overflow flag.
- **Weights:**
  - arr_w holds its value between jobs.
  - It is overwritten only by LOAD beats.

## Timing
- **Reset values:** state = IDLE; busy, done, w_ready, a_ready, r_valid, arr_en and arr_clr = 0; arr_w, arr_left, r_data and all skew/token registers = 0.
- **Reset mid-job:** an rst in any state aborts the job. No done pulse.
- **Latency:** a vector accepted at adv edge e0 appears with r_valid = 1 after the adv edge e0+2N (8 for N=4).
- **Throughput:** one vector per cycle while unstalled.
- **Stall (r_valid && !r_ready):**
  - arr_en = 0 and a_ready = 0.
  - The whole pipeline, including the PEs, freezes.
  - r_data is held stable.
- **Job end:**
  - The last result is delivered before done.
  - done is asserted the cycle after the 2N-th drain adv.
- **M = 255:** counter wrap must not occur. The vector counter is 8 bits, compared against M.

## Structure
- Header sysa_pkg holds the N/DW/AW defaults and the state encodings (IDLE=0, LOAD=1, FEED=2, DRAIN=3, DONE=4).
- One sub-module, sysa_dly: a parametric adv-gated delay line (width, depth ≥ 0).
  - Instantiated per lane for skew (depth i+1) and de-skew (depth N-1-j).

## Test plan
- **Identity:** W = I, a = [1,2,3,4] → r_data = [1,2,3,4]; r_valid after 8 advs; done pulse; busy returns to 0.
- **Full matrix, 3 back-to-back vectors:** W[i][j] = i+j+1; vectors [1,0,0,0], [0,1,0,0], [1,1,1,1] → results [1,2,3,4], [2,3,4,5], [10,14,18,22] on consecutive cycles.
- **Overflow:** all W = 255, a = [255,255,255,255] → every lane = 63492 (260100 mod 65536).
- **Backpressure:** r_ready held low for 5 cycles mid-stream.
  - arr_en = 0 and a_ready = 0 during the hold, r_data is held.
  - Results afterwards are identical to the unstalled run.
- **Bubbles:** a_valid toggling 1-0-1 → no spurious r_valid; results are unchanged.
- **Corners:**
  - M = 0 → done right after LOAD, no r_valid.
  - start while busy → ignored.
  - rst during FEED → all outputs 0, IDLE; a new job then runs correctly.
